// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow controller.
// State encodings, score width and flash divider.
package pong_pkg;

  localparam int SCORE_W   = 3;
  localparam int FLASH_DIV = 8;
  localparam int FLASH_W   = $clog2(FLASH_DIV);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4,
    S_PAUSE    = 3'd5
  } state_e;

  function automatic logic is_center(state_e s);
    return (s == S_IDLE) || (s == S_SERVE) ||
           (s == S_GAMEOVER);
  endfunction

  function automatic logic is_playing(state_e s);
    return (s == S_SERVE) || (s == S_PLAY) ||
           (s == S_POINT) || (s == S_PAUSE);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Raw button synchronizer plus rising-edge detector.
// pulse is high for one mclk, two edges after the raw rise.
module btn_edge_sync (
  input  logic mclk,
  input  logic reset_n,
  input  logic raw,
  output logic pulse
);

  logic [2:0] sh_q;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= {sh_q[1:0], raw};
    end
  end

  assign pulse = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/match_sequencer.sv
// Pong match flow: IDLE/SERVE/PLAY/POINT/GAMEOVER, scores, flash.
// Define PONG_PAUSE_EN to add the pause_btn input and PAUSE state.
module match_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = 120,
  parameter int POINT_TICKS = 60,
  parameter int CNT_W       = 8
) (
  input  logic               mclk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               start_btn,
  input  logic               point1,
  input  logic               point2,
`ifdef PONG_PAUSE_EN
  input  logic               pause_btn,
`endif
  output logic               ball_run,
  output logic               ball_center,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               playing,
  output logic               winner,
  output logic               flash,
  output logic [2:0]         state_o
);

  localparam logic [CNT_W-1:0] SERVE_LD =
    CNT_W'(SERVE_TICKS);
  localparam logic [CNT_W-1:0] POINT_LD =
    CNT_W'(POINT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);
  localparam logic [SCORE_W-1:0] WIN_LD =
    SCORE_W'(WIN_SCORE);
  localparam logic [FLASH_W-1:0] PH_LAST =
    FLASH_W'(FLASH_DIV - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] s1_q, s1_d;
  logic [SCORE_W-1:0] s2_q, s2_d;
  logic [FLASH_W-1:0] ph_q, ph_d;
  logic               dir_q, dir_d;
  logic               win_q, win_d;
  logic               flash_q, flash_d;
  logic               run_q, run_d;
  logic               ctr_q, ctr_d;
  logic               play_q, play_d;
  logic               start_p;

  btn_edge_sync u_start (
    .mclk    (mclk),
    .reset_n (reset_n),
    .raw     (start_btn),
    .pulse   (start_p)
  );

`ifdef PONG_PAUSE_EN
  logic pause_p;

  btn_edge_sync u_pause (
    .mclk    (mclk),
    .reset_n (reset_n),
    .raw     (pause_btn),
    .pulse   (pause_p)
  );
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    dir_d   = dir_q;
    win_d   = win_q;
    ph_d    = ph_q;
    flash_d = flash_q;
    unique case (1'b1)
      (state_q == S_IDLE),
      (state_q == S_GAMEOVER): begin
        if (start_p) begin
          state_d = S_SERVE;
          cnt_d   = SERVE_LD;
          s1_d    = '0;
          s2_d    = '0;
        end
      end
      (state_q == S_SERVE): begin
        if (tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      (state_q == S_PLAY): begin
        if (point1 & point2) begin
          state_d = S_POINT;
          cnt_d   = POINT_LD;
        end else if (point1 ^ point2) begin
          if (point1) s1_d = s1_q + 1'b1;
          else        s2_d = s2_q + 1'b1;
          if ((point1 ? s1_d : s2_d) == WIN_LD) begin
            state_d = S_GAMEOVER;
            win_d   = point1;
          end else begin
            // serve goes toward the player who just scored
            state_d = S_POINT;
            cnt_d   = POINT_LD;
            dir_d   = point2;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (pause_p) begin
          state_d = S_PAUSE;
        end
`endif
      end
      (state_q == S_POINT): begin
        if (tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = S_SERVE;
            cnt_d   = SERVE_LD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
`ifdef PONG_PAUSE_EN
      (state_q == S_PAUSE): begin
        if (pause_p) state_d = S_PLAY;
      end
`endif
      default: begin
      end
    endcase
    // flash restarts from dark on every state change
    if (state_d != state_q) begin
      ph_d    = '0;
      flash_d = 1'b0;
    end else if (tick && ((state_q == S_POINT) ||
                          (state_q == S_GAMEOVER))) begin
      ph_d = ph_q + 1'b1;
      if (ph_q == PH_LAST) flash_d = ~flash_q;
    end
    run_d  = (state_d == S_PLAY);
    ctr_d  = is_center(state_d);
    play_d = is_playing(state_d);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      dir_q   <= 1'b0;
      win_q   <= 1'b0;
      ph_q    <= '0;
      flash_q <= 1'b0;
      run_q   <= 1'b0;
      ctr_q   <= 1'b1;
      play_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      ph_q    <= ph_d;
      flash_q <= flash_d;
      run_q   <= run_d;
      ctr_q   <= ctr_d;
      play_q  <= play_d;
    end
  end

  assign ball_run    = run_q;
  assign ball_center = ctr_q;
  assign serve_dir   = dir_q;
  assign score1      = s1_q;
  assign score2      = s2_q;
  assign playing     = play_q;
  assign winner      = win_q;
  assign flash       = flash_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Randomized self-checking bench for match_sequencer.
// Build with PONG_PAUSE_EN to also cover the pause feature.
module tb_match_sequencer;

  localparam int SERVE_T = 120;
  localparam int POINT_T = 60;
  localparam int WIN     = 5;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_POINT = 3'd3;
  localparam logic [2:0] ST_GO    = 3'd4;
  localparam logic [2:0] ST_PAUSE = 3'd5;

  logic mclk = 1'b0;
  logic reset_n = 1'b0;
  logic tick = 1'b0;
  logic start_btn = 1'b0;
  logic point1 = 1'b0;
  logic point2 = 1'b0;
`ifdef PONG_PAUSE_EN
  logic pause_btn = 1'b0;
`endif
  logic       ball_run, ball_center, serve_dir;
  logic       playing, winner, flash;
  logic [2:0] score1, score2, state_o;

  int n_chk = 0;
  int n_fail = 0;
  int m1 = 0;
  int m2 = 0;
  logic mdir = 1'b0;
  bit at_go = 1'b0;

  match_sequencer dut (
    .mclk        (mclk),
    .reset_n     (reset_n),
    .tick        (tick),
    .start_btn   (start_btn),
    .point1      (point1),
    .point2      (point2),
`ifdef PONG_PAUSE_EN
    .pause_btn   (pause_btn),
`endif
    .ball_run    (ball_run),
    .ball_center (ball_center),
    .serve_dir   (serve_dir),
    .score1      (score1),
    .score2      (score2),
    .playing     (playing),
    .winner      (winner),
    .flash       (flash),
    .state_o     (state_o)
  );

  always #5 mclk = ~mclk;

  task automatic cyc(input logic t, input logic p1,
                     input logic p2);
    tick = t;
    point1 = p1;
    point2 = p2;
    @(posedge mclk);
    #1;
    tick = 1'b0;
    point1 = 1'b0;
    point2 = 1'b0;
  endtask

  task automatic tick_one(input bit noise);
    int gap;
    logic a, b;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      a = noise && ($urandom_range(0, 1) == 1);
      b = noise && ($urandom_range(0, 1) == 1);
      cyc(1'b0, a, b);
    end
    cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_scores(input string nm);
    n_chk++;
    if (score1 !== 3'(m1) || score2 !== 3'(m2)) begin
      n_fail++;
      $display("FAIL %s: scores %0d/%0d want %0d/%0d",
               nm, score1, score2, m1, m2);
    end
  endtask

  task automatic press(input bit which, input bit check);
    if (which == 1'b0) start_btn = 1'b1;
`ifdef PONG_PAUSE_EN
    else pause_btn = 1'b1;
`endif
    for (int i = 1; i <= 3; i++) begin
      @(posedge mclk);
      #1;
      if (check) begin
        n_chk++;
        if (i < 3 && (playing !== 1'b0 ||
                      state_o !== ST_IDLE)) begin
          n_fail++;
          $display("FAIL start_lat edge%0d: playing=%b st=%0d want 0/0",
                   i, playing, state_o);
        end
        if (i == 3 && (playing !== 1'b1 ||
                       ball_center !== 1'b1 ||
                       state_o !== ST_SERVE)) begin
          n_fail++;
          $display("FAIL start_edge3: playing=%b ctr=%b st=%0d want 1/1/1",
                   playing, ball_center, state_o);
        end
      end
    end
    start_btn = 1'b0;
`ifdef PONG_PAUSE_EN
    pause_btn = 1'b0;
`endif
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_serve(input int from_k, input bit noise);
    for (int k = from_k; k <= SERVE_T; k++) begin
      tick_one(noise);
      if (k < SERVE_T) begin
        n_chk++;
        if (ball_run !== 1'b0 || state_o !== ST_SERVE ||
            ball_center !== 1'b1) begin
          n_fail++;
          $display("FAIL serve_hold k=%0d: run=%b st=%0d ctr=%b want 0/1/1",
                   k, ball_run, state_o, ball_center);
        end
      end
    end
    n_chk++;
    if (ball_run !== 1'b1 || state_o !== ST_PLAY ||
        ball_center !== 1'b0 || playing !== 1'b1) begin
      n_fail++;
      $display("FAIL serve_release: run=%b st=%0d ctr=%b want 1/2/0",
               ball_run, state_o, ball_center);
    end
    check_scores("serve_scores");
  endtask

  task automatic run_point(input bit noise);
    for (int k = 1; k <= POINT_T; k++) begin
      tick_one(noise);
      n_chk++;
      if (k < POINT_T) begin
        if (state_o !== ST_POINT || ball_run !== 1'b0 ||
            flash !== logic'((k / 8) % 2)) begin
          n_fail++;
          $display("FAIL point_flash k=%0d: st=%0d run=%b flash=%b want 3/0/%0d",
                   k, state_o, ball_run, flash, (k / 8) % 2);
        end
      end else if (state_o !== ST_SERVE || flash !== 1'b0) begin
        n_fail++;
        $display("FAIL point_expire: st=%0d flash=%b want 1/0",
                 state_o, flash);
      end
    end
    check_scores("point_scores");
  endtask

  task automatic score_event(input logic p1, input logic p2,
                             output bit over);
    logic [2:0] est;
    over = 1'b0;
    est = ST_POINT;
    cyc(1'b0, p1, p2);
    if (p1 ^ p2) begin
      if (p1) m1++;
      else m2++;
      if (m1 == WIN || m2 == WIN) begin
        over = 1'b1;
        est = ST_GO;
      end else begin
        mdir = p2;
      end
    end
    n_chk++;
    if (state_o !== est || serve_dir !== mdir ||
        ball_run !== 1'b0) begin
      n_fail++;
      $display("FAIL score_evt %b%b: st=%0d dir=%b run=%b want %0d/%b/0",
               p1, p2, state_o, serve_dir, ball_run, est, mdir);
    end
    check_scores("evt_scores");
    if (over) begin
      n_chk++;
      if (winner !== p1 || playing !== 1'b0 ||
          ball_center !== 1'b1) begin
        n_fail++;
        $display("FAIL gameover: win=%b play=%b ctr=%b want %b/0/1",
                 winner, playing, ball_center, p1);
      end
    end
    at_go = over;
  endtask

  task automatic new_match();
    press(1'b0, 1'b0);
    m1 = 0;
    m2 = 0;
    at_go = 1'b0;
    n_chk++;
    if (state_o !== ST_SERVE || score1 !== 3'd0 ||
        score2 !== 3'd0) begin
      n_fail++;
      $display("FAIL restart: st=%0d scores %0d/%0d want 1 0/0",
               state_o, score1, score2);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge mclk);
    #1;
    n_chk++;
    if (state_o !== ST_IDLE || score1 !== 3'd0 ||
        score2 !== 3'd0 || ball_center !== 1'b1 ||
        ball_run !== 1'b0 || playing !== 1'b0 ||
        flash !== 1'b0 || winner !== 1'b0 ||
        serve_dir !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: st=%0d s=%0d/%0d ctr=%b run=%b want 0 0/0 1 0",
               state_o, score1, score2, ball_center, ball_run);
    end
    reset_n = 1'b1;
    repeat (4) cyc(1'b1, 1'b1, 1'b0);
    n_chk++;
    if (state_o !== ST_IDLE || score1 !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_ignore: st=%0d s1=%0d want 0/0",
               state_o, score1);
    end
  endtask

  task automatic test_start();
    press(1'b0, 1'b1);
    run_serve(1, 1'b1);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0);
    run_serve(1, 1'b0);
  endtask

  task automatic test_start_ignored();
    bit over;
    score_event(1'b1, 1'b0, over);
    run_point(1'b0);
    for (int k = 1; k <= 10; k++) tick_one(1'b0);
    press(1'b0, 1'b0);
    n_chk++;
    if (state_o !== ST_SERVE) begin
      n_fail++;
      $display("FAIL start_in_serve: st=%0d want 1", state_o);
    end
    run_serve(11, 1'b1);
  endtask

  task automatic test_point();
    bit over;
    score_event(1'b0, 1'b1, over);
    run_point(1'b1);
    run_serve(1, 1'b1);
  endtask

  task automatic test_both();
    bit over;
    score_event(1'b1, 1'b1, over);
    run_point(1'b0);
    run_serve(1, 1'b0);
  endtask

  task automatic test_random_match();
    bit over;
    int r;
    over = 1'b0;
    for (int n = 0; n < 40 && !over; n++) begin
      r = $urandom_range(0, 4);
      if (r < 2) score_event(1'b1, 1'b0, over);
      else if (r < 4) score_event(1'b0, 1'b1, over);
      else score_event(1'b1, 1'b1, over);
      if (!over) begin
        run_point(1'b1);
        run_serve(1, 1'b1);
      end
    end
    n_chk++;
    if (state_o !== ST_GO) begin
      n_fail++;
      $display("FAIL random_end: st=%0d want 4", state_o);
    end
  endtask

  task automatic test_p1_wins();
    bit over;
    new_match();
    run_serve(1, 1'b1);
    for (int i = 1; i <= WIN; i++) begin
      score_event(1'b1, 1'b0, over);
      if (!over) begin
        run_point(1'b0);
        run_serve(1, 1'b0);
      end
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    n_chk++;
    if (score1 !== 3'd5 || score2 !== 3'd0 ||
        winner !== 1'b1 || state_o !== ST_GO) begin
      n_fail++;
      $display("FAIL p1_win: s=%0d/%0d win=%b st=%0d want 5/0 1 4",
               score1, score2, winner, state_o);
    end
    for (int k = 1; k <= 16; k++) begin
      tick_one(1'b1);
      n_chk++;
      if (flash !== logic'((k / 8) % 2) || state_o !== ST_GO) begin
        n_fail++;
        $display("FAIL go_flash k=%0d: flash=%b st=%0d want %0d/4",
                 k, flash, state_o, (k / 8) % 2);
      end
    end
    check_scores("go_frozen");
  endtask

`ifdef PONG_PAUSE_EN
  task automatic test_pause();
    new_match();
    run_serve(1, 1'b0);
    press(1'b1, 1'b0);
    n_chk++;
    if (state_o !== ST_PAUSE || ball_run !== 1'b0 ||
        playing !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_enter: st=%0d run=%b play=%b want 5/0/1",
               state_o, ball_run, playing);
    end
    cyc(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) tick_one(1'b1);
    check_scores("pause_ignore");
    press(1'b1, 1'b0);
    n_chk++;
    if (state_o !== ST_PLAY || ball_run !== 1'b1) begin
      n_fail++;
      $display("FAIL pause_resume: st=%0d run=%b want 2/1",
               state_o, ball_run);
    end
    check_scores("resume_scores");
  endtask
`endif

  task automatic test_async_reset();
    bit over;
    if (at_go) begin
      new_match();
      run_serve(1, 1'b0);
    end
    score_event(1'b0, 1'b1, over);
    run_point(1'b0);
    for (int k = 0; k < 7; k++) tick_one(1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (state_o !== ST_IDLE || score1 !== 3'd0 ||
        score2 !== 3'd0 || serve_dir !== 1'b0 ||
        ball_center !== 1'b1 || playing !== 1'b0 ||
        winner !== 1'b0 || flash !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: st=%0d s=%0d/%0d dir=%b ctr=%b want 0 0/0 0 1",
               state_o, score1, score2, serve_dir, ball_center);
    end
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_start();
    test_start_ignored();
    test_point();
    test_both();
    test_random_match();
    test_p1_wins();
`ifdef PONG_PAUSE_EN
    test_pause();
`endif
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
